// File: rtl/sum_display_pkg.sv
// Shared constants for the adder-sum display driver: FSM encodings, 7-segment
// codes (active-low, {g,f,e,d,c,b,a}) and the double-dabble helper.
package sum_display_pkg;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned ITER_COUNT = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd7seg_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with a blank override.
module bcd7seg_decode
  import sum_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode one digit; non-decimal codes also render blank.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_display_driver.sv
// Captures the 9-bit adder result {Cout,S}, converts it to 3-digit BCD with a
// sequential double-dabble engine and scans the digits onto a common-anode
// 7-segment display. Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros.
module sum_display_driver
  import sum_display_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  S_in,
  input  logic        Cout_in,
  input  logic        load,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int unsigned CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [3:0] ITER_LAST = 4'(ITER_COUNT - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [11:0]       acc_q, acc_d;
  logic [11:0]       acc_adj;
  logic [3:0]        iter_q, iter_d;
  logic [11:0]       bcd_out_q, bcd_out_d;
  logic              have_q, have_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        idx_q;
  logic [3:0]        digit;
  logic              blank;

  // Conversion FSM next-state: capture, nine correct-and-shift steps, then publish.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    bcd_out_d = bcd_out_q;
    have_d    = have_q;
    acc_adj   = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d = {Cout_in, S_in};
          acc_d   = '0;
          iter_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, shift_d} = {acc_adj[10:0], shift_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == ITER_LAST) begin
          bcd_out_d = acc_d;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        have_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Conversion state registers; reset aborts any in-flight conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      bcd_out_q <= '0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      bcd_out_q <= bcd_out_d;
      have_q    <= have_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign bcd_valid = (state_q == ST_DONE);
  assign bcd_out   = bcd_out_q;

  // Free-running refresh counter; each wrap advances the scanned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Anode decode and digit select from the held result only.
  always_comb begin
    an    = 3'b110;
    digit = bcd_out_q[3:0];
    blank = !have_q;
    case (idx_q)
      2'd1: begin
        an    = 3'b101;
        digit = bcd_out_q[7:4];
`ifdef LEAD_ZERO_BLANK_EN
        if (bcd_out_q[11:4] == 8'd0) blank = 1'b1;
`endif
      end
      2'd2: begin
        an    = 3'b011;
        digit = bcd_out_q[11:8];
`ifdef LEAD_ZERO_BLANK_EN
        if (bcd_out_q[11:8] == 4'd0) blank = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  bcd7seg_decode u_decode (
    .digit (digit),
    .blank (blank),
    .seg   (seg)
  );

endmodule
